// File: rtl/tmr_scrub_reg_pkg.sv
// Shared types and constants for the triple-modular-redundant scrubbing register.
package tmr_scrub_reg_pkg;

   typedef enum logic {
      NORMAL = 1'b0,
      SCRUB  = 1'b1
   } state_t;

   localparam logic [1:0] LANE_A = 2'd0;
   localparam logic [1:0] LANE_B = 2'd1;
   localparam logic [1:0] LANE_C = 2'd2;

   // True when two or more lanes disagree with the vote at the same time.
   function automatic logic multi_lane(input logic [2:0] m);
      return (m[0] & m[1]) | (m[1] & m[2]) | (m[0] & m[2]);
   endfunction

endpackage

// File: rtl/tmr_scrub_reg_voter.sv
// Bitwise 2-of-3 majority voter over three equal-width lanes.
module tmr_scrub_reg_voter #(
   parameter int data_len = 16
) (
   input  logic [data_len-1:0] a,
   input  logic [data_len-1:0] b,
   input  logic [data_len-1:0] c,
   output logic [data_len-1:0] y
);

   assign y = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/tmr_scrub_reg.sv
// Triplicated register with majority output, background scrubbing,
// per-lane saturating error counters and a sticky multi-lane alarm.
module tmr_scrub_reg
   import tmr_scrub_reg_pkg::*;
#(
   parameter int data_len = 16,
   parameter int cnt_len  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   input  logic [data_len-1:0]   wr_data,
   output logic                  wr_ready,
   input  logic                  inj_valid,
   input  logic [1:0]            inj_lane,
   input  logic [data_len-1:0]   inj_mask,
   input  logic                  clr,
   output logic [data_len-1:0]   out,
   output logic [2:0]            mismatch,
   output logic                  corr_pulse,
   output logic                  alarm,
   output logic [3*cnt_len-1:0]  err_cnt,
   output state_t                fsm_state
);

   // Handshake: a write completes on a rising edge where wr_valid and
   // wr_ready are both high; the source holds wr_data/wr_valid until then.

   (* keep = "true" *) logic [data_len-1:0] lane_a;
   (* keep = "true" *) logic [data_len-1:0] lane_b;
   (* keep = "true" *) logic [data_len-1:0] lane_c;

   logic [data_len-1:0] vote;
   logic [2:0]          diff;
   logic [cnt_len-1:0]  cnt [3];
   state_t              state, state_next;
   logic                wr_fire, inj_fire, do_cmp, do_scrub;

   tmr_scrub_reg_voter #(.data_len(data_len)) u_voter (
      .a (lane_a),
      .b (lane_b),
      .c (lane_c),
      .y (vote)
   );

   assign diff      = {|(lane_c ^ vote), |(lane_b ^ vote), |(lane_a ^ vote)};
   assign out       = vote;
   assign err_cnt   = {cnt[2], cnt[1], cnt[0]};
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= NORMAL;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      wr_ready   = 1'b0;
      corr_pulse = 1'b0;
      wr_fire    = 1'b0;
      inj_fire   = 1'b0;
      do_cmp     = 1'b0;
      do_scrub   = 1'b0;
      case (state)
         NORMAL: begin
            wr_ready = !rst;
            if (wr_valid) begin
               wr_fire = 1'b1;
            end else if (inj_valid && inj_lane != 2'd3) begin
               inj_fire = 1'b1;
            end else begin
               // Compare only on quiet cycles so a fresh write or injection settles first.
               do_cmp = 1'b1;
               if (|diff) state_next = SCRUB;
            end
         end
         SCRUB: begin
            corr_pulse = !rst;
            do_scrub   = 1'b1;
            state_next = NORMAL;
         end
         default: state_next = NORMAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_a   <= '0;
         lane_b   <= '0;
         lane_c   <= '0;
         mismatch <= '0;
         alarm    <= 1'b0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         if (wr_fire) begin
            lane_a   <= wr_data;
            lane_b   <= wr_data;
            lane_c   <= wr_data;
            mismatch <= '0;
         end else if (inj_fire) begin
            case (inj_lane)
               LANE_A:  lane_a <= lane_a ^ inj_mask;
               LANE_B:  lane_b <= lane_b ^ inj_mask;
               LANE_C:  lane_c <= lane_c ^ inj_mask;
               default: ;
            endcase
            mismatch <= '0;
         end else if (do_cmp) begin
            mismatch <= diff;
            if (multi_lane(diff)) alarm <= 1'b1;
         end else if (do_scrub) begin
            lane_a   <= vote;
            lane_b   <= vote;
            lane_c   <= vote;
            mismatch <= '0;
            for (int i = 0; i < 3; i++)
               if (mismatch[i] && cnt[i] != '1) cnt[i] <= cnt[i] + cnt_len'(1);
         end
         // clr is applied last so it overrides a same-edge increment or alarm set.
         if (clr) begin
            alarm <= 1'b0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Self-checking bench for tmr_scrub_reg: directed scenarios plus random traffic
// compared every cycle against a lane-array reference model.
module tb_tmr_scrub_reg;
   import tmr_scrub_reg_pkg::*;

   localparam int DW   = 16;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            wr_valid = 1'b0;
   logic [DW-1:0]   wr_data = '0;
   logic            wr_ready;
   logic            inj_valid = 1'b0;
   logic [1:0]      inj_lane = '0;
   logic [DW-1:0]   inj_mask = '0;
   logic            clr = 1'b0;
   logic [DW-1:0]   out;
   logic [2:0]      mismatch;
   logic            corr_pulse;
   logic            alarm;
   logic [3*CW-1:0] err_cnt;
   state_t          fsm_state;

   always #5 clk = ~clk;

   tmr_scrub_reg #(.data_len(DW), .cnt_len(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .inj_valid  (inj_valid),
      .inj_lane   (inj_lane),
      .inj_mask   (inj_mask),
      .clr        (clr),
      .out        (out),
      .mismatch   (mismatch),
      .corr_pulse (corr_pulse),
      .alarm      (alarm),
      .err_cnt    (err_cnt),
      .fsm_state  (fsm_state)
   );

   int n_total = 0;
   int n_pass  = 0;
   int corr_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: three lanes as an array, vote by counting ones per bit.
   logic [DW-1:0] m_lane [3];
   int            m_cnt  [3];
   logic [2:0]    m_mm;
   bit            m_alarm, m_scrub, m_valid;

   function automatic logic [DW-1:0] maj(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                         input logic [DW-1:0] z);
      logic [DW-1:0] r;
      for (int b = 0; b < DW; b++)
         r[b] = (int'(x[b]) + int'(y[b]) + int'(z[b])) >= 2;
      return r;
   endfunction

   always @(posedge clk) begin : model
      logic [DW-1:0] v;
      logic [2:0]    d;
      int            nd;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_lane[i] = '0;
            m_cnt[i]  = 0;
         end
         m_mm = '0; m_alarm = 0; m_scrub = 0; m_valid = 1;
      end else if (m_valid) begin
         v = maj(m_lane[0], m_lane[1], m_lane[2]);
         if (m_scrub) begin
            for (int i = 0; i < 3; i++) begin
               if (m_mm[i] && m_cnt[i] < CMAX) m_cnt[i]++;
               m_lane[i] = v;
            end
            m_mm = '0; m_scrub = 0;
         end else if (wr_valid) begin
            for (int i = 0; i < 3; i++) m_lane[i] = wr_data;
            m_mm = '0;
         end else if (inj_valid && inj_lane < 3) begin
            m_lane[inj_lane] = m_lane[inj_lane] ^ inj_mask;
            m_mm = '0;
         end else begin
            nd = 0;
            for (int i = 0; i < 3; i++) begin
               d[i] = (m_lane[i] != v);
               nd += int'(d[i]);
            end
            m_mm = d;
            if (nd > 0) m_scrub = 1;
            if (nd >= 2) m_alarm = 1;
         end
         if (clr) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            m_alarm = 0;
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [3*CW-1:0] exp_cnt;
      if (m_valid) begin
         for (int i = 0; i < 3; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
         check("out", out, maj(m_lane[0], m_lane[1], m_lane[2]));
         check("mismatch", mismatch, m_mm);
         check("corr_pulse", corr_pulse, m_scrub && !rst);
         check("wr_ready", wr_ready, !rst && !m_scrub);
         check("alarm", alarm, m_alarm);
         check("err_cnt", err_cnt, exp_cnt);
         check("fsm_state", fsm_state, m_scrub ? SCRUB : NORMAL);
         if (corr_pulse) corr_seen++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic do_write(input logic [DW-1:0] d, output int stalls);
      bit done;
      done = 0;
      stalls = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      for (int k = 0; k < 16 && !done; k++) begin
         @(negedge clk);
         if (wr_ready) done = 1;
         else stalls++;
         tick();
      end
      wr_valid = 1'b0;
      if (!done) begin
         n_total++;
         $display("FAIL write_timeout: got no wr_ready expected acceptance within 16 cycles");
      end
   endtask

   task automatic do_inject(input logic [1:0] l, input logic [DW-1:0] m);
      inj_valid = 1'b1;
      inj_lane  = l;
      inj_mask  = m;
      tick();
      inj_valid = 1'b0;
      inj_mask  = '0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int st, c0, r;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out", out, 16'h0000);
      check("rst_cnt", err_cnt, 24'h0);
      check("rst_ready", wr_ready, 1'b1);
      check("rst_alarm", alarm, 1'b0);

      // Plain write, latency one
      c0 = corr_seen;
      do_write(16'hA5A5, st);
      @(negedge clk);
      check("w_out", out, 16'hA5A5);
      check("w_model", maj(m_lane[0], m_lane[1], m_lane[2]), 16'hA5A5);
      check("w_mm", mismatch, 3'b000);
      idle(4);
      check("w_no_corr", corr_seen - c0, 0);

      // Single-lane fault on lane 1
      c0 = corr_seen;
      do_inject(2'd1, 16'h0001);
      @(posedge clk);
      @(negedge clk);
      check("i1_out", out, 16'hA5A5);
      check("i1_mm", mismatch, 3'b010);
      check("i1_corr", corr_pulse, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("i1_cnt", err_cnt, 24'h000100);
      check("i1_alarm", alarm, 1'b0);
      idle(3);
      check("i1_pulses", corr_seen - c0, 1);

      // Two separate single faults, lanes 0 and 2
      do_reset();
      do_write(16'hA5A5, st);
      c0 = corr_seen;
      do_inject(2'd0, 16'h0001);
      idle(3);
      do_inject(2'd2, 16'h0100);
      idle(3);
      check("i02_pulses", corr_seen - c0, 2);
      check("i02_cnt", err_cnt, 24'h010001);
      check("i02_model_cnt", 24'(m_cnt[2] * 65536 + m_cnt[0]), 24'h010001);
      check("i02_alarm", alarm, 1'b0);

      // Back-to-back injections on lanes 0 and 2 before any compare
      do_reset();
      do_write(16'hA5A5, st);
      do_inject(2'd0, 16'h0001);
      do_inject(2'd2, 16'h0002);
      @(posedge clk);
      @(negedge clk);
      check("dbl_mm", mismatch, 3'b101);
      check("dbl_alarm", alarm, 1'b1);
      check("dbl_out", out, 16'hA5A5);
      idle(3);
      check("dbl_alarm_sticky", alarm, 1'b1);
      do_clr();
      @(negedge clk);
      check("clr_alarm", alarm, 1'b0);
      check("clr_cnt", err_cnt, 24'h0);

      // Write held across a scrub, then write racing an injection
      do_reset();
      do_write(16'h1111, st);
      do_inject(2'd0, 16'h8000);
      tick();
      do_write(16'h1234, st);
      check("stall_cycles", st, 1);
      @(negedge clk);
      check("stall_out", out, 16'h1234);
      c0 = corr_seen;
      wr_valid = 1'b1; wr_data = 16'h5A5A;
      inj_valid = 1'b1; inj_lane = 2'd2; inj_mask = 16'hFFFF;
      tick();
      wr_valid = 1'b0; inj_valid = 1'b0; inj_mask = '0;
      @(negedge clk);
      check("race_out", out, 16'h5A5A);
      check("race_mm", mismatch, 3'b000);
      do_inject(2'd2, 16'h0000);
      do_inject(2'd3, 16'hFFFF);
      idle(3);
      check("race_no_corr", corr_seen - c0, 0);

      // Lane 2 hammered past saturation
      do_reset();
      do_write(16'(ipsrand()), st);
      for (int k = 0; k < 300; k++) begin
         do_inject(2'd2, 16'($urandom_range(1, 16'hFFFF)));
         idle(2);
      end
      @(negedge clk);
      check("sat_cnt", err_cnt, 24'hFF0000);
      check("sat_alarm", alarm, 1'b0);

      // clr on the scrub edge wins over the increment
      do_inject(2'd2, 16'h0001);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      check("clr_win_cnt", err_cnt, 24'h0);

      // rst during a scrub aborts it without counting
      do_inject(2'd1, 16'h0004);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_scrub_cnt", err_cnt, 24'h0);
      check("rst_scrub_out", out, 16'h0000);

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         r = $urandom_range(0, 99);
         if (r < 25) begin
            do_write(16'($urandom), st);
         end else if (r < 60) begin
            do_inject(2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
         end else if (r < 66) begin
            do_clr();
         end else if (r < 68) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end else begin
            clr = ($urandom_range(0, 15) == 0);
            tick();
            clr = 1'b0;
         end
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   function automatic int ipsrand();
      return int'($urandom_range(0, 16'hFFFF));
   endfunction

endmodule

// File: doc/tmr_scrub_reg.md
TMR_SCRUB_REG -- requirements
Module: tmr_scrub_reg

Interface
REQ-001 Parameter data_len, default 16, is the width of the protected word.
REQ-002 Parameter cnt_len, default 8, is the width of each per-lane error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  write request.
REQ-006 wr_data  input  data_len  word to store in all three lanes.
REQ-007 wr_ready  output  1  write acceptance; a write completes on a clock edge with wr_valid and wr_ready both high.
REQ-008 inj_valid  input  1  fault-injection request, for test and radiation emulation.
REQ-009 inj_lane  input  2  target lane for injection: 0, 1 or 2; the value 3 is ignored.
REQ-010 inj_mask  input  data_len  bits to XOR into the target lane.
REQ-011 clr  input  1  clears the error counters and the alarm.
REQ-012 out  output  data_len  bitwise majority of the three lanes.
REQ-013 mismatch  output  3  registered per-lane flag: lane i differed from the vote.
REQ-014 corr_pulse  output  1  one-cycle strobe when a scrub is performed.
REQ-015 alarm  output  1  sticky multi-lane fault flag.
REQ-016 err_cnt  output  3*cnt_len  per-lane saturating counters; lane 0 occupies the LSBs.

Function
REQ-017 out SHALL be combinational (a&b)|(b&c)|(a&c) over lanes A, B and C at all times.
REQ-018 The FSM SHALL have exactly two states: NORMAL and SCRUB.
REQ-019 In NORMAL, wr_ready=1.
- An accepted write loads wr_data into all three lanes.
- out reflects the new word in the next cycle (latency 1).
REQ-020 In NORMAL, when neither a write nor an accepted injection is occurring, and any lane differs from the vote:
- mismatch is registered.
- The FSM enters SCRUB.
REQ-021 In SCRUB, wr_ready=0, and injections SHALL be dropped.
- All three lanes are loaded with the vote.
- corr_pulse=1 for that cycle.
- The err_cnt of each flagged lane increments by one.
- The FSM returns to NORMAL.
REQ-022 Counters SHALL saturate at 2^cnt_len-1 and never wrap.
REQ-023 If two or more mismatch bits are set when the FSM enters SCRUB, alarm SHALL set; it stays high until clr or rst.
REQ-024 In NORMAL, an injection XORs inj_mask into the target lane on the edge; the compare is evaluated in the following cycle.
REQ-025 Simultaneous write and injection: the write wins and the injection is discarded.
REQ-026 clr coinciding with a counter increment: clr wins, and the counter becomes 0.
REQ-027 A write presented during SCRUB SHALL stall; wr_data and wr_valid must be held by the source until accepted.
REQ-028 inj_mask=0 SHALL cause no mismatch and no state change.
REQ-029 mismatch SHALL clear to 0 on the edge that leaves SCRUB.

Reset
REQ-030 On rst, all three lanes SHALL become 0, so out=0.
REQ-031 On rst: state=NORMAL, mismatch=0, corr_pulse=0, alarm=0, err_cnt=0.
REQ-032 On rst: wr_ready=0 in the reset cycle and 1 from the first cycle after.
REQ-033 rst asserted during SCRUB SHALL abort the scrub with no counter increment.
REQ-034 rst SHALL take priority over write, injection and clr.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state enum (NORMAL, SCRUB);
- lane index constants LANE_A=0, LANE_B=1, LANE_C=2.
REQ-036 The bitwise majority function SHALL be instantiated as the existing combinational voter sub-module (three inputs of data_len, one output).
REQ-037 The three lanes SHALL be distinct registers that synthesis does not merge (keep attribute applied).

Verification
REQ-038 Write 16'hA5A5 after reset: out=16'hA5A5 one cycle later; mismatch=0; corr_pulse never asserts.
REQ-039 Inject lane 1 with mask 16'h0001 on word 16'hA5A5:
- out stays 16'hA5A5;
- mismatch=3'b010;
- one corr_pulse;
- err_cnt lane 1 = 1;
- alarm=0.
REQ-040 Inject lane 0 with mask 16'h0001, then after the scrub inject lane 2 with mask 16'h0100:
- two corr_pulses;
- counts lane 0 = 1, lane 2 = 1;
- alarm=0.
REQ-041 Lanes preloaded via two back-to-back injections, lane 0 mask 16'h0001 then lane 2 mask 16'h0002, with no scrub between (the second injection lands in the cycle after the first, before the compare of that cycle):
- mismatch=3'b101;
- alarm=1;
- after clr, alarm=0 and all counts = 0.
REQ-042 Repeated single-lane faults on lane 2, 300 times: err_cnt lane 2 saturates at 255.
REQ-043 Write held during SCRUB: wr_ready=0 for exactly one cycle, then the write is accepted; a simultaneous write and injection yields out=wr_data with no scrub.
